// File: rtl/direction_arbiter_if.sv
// Button, autopilot and tick inputs plus committed-direction outputs of the direction arbiter.
// Bit order of the 4-bit vectors is {right, left, down, up}.
interface direction_arbiter_if;
  logic [3:0] i_btn;
  logic [3:0] i_auto_dir;
  logic       i_autopilot;
  logic       i_tick;
  logic       o_up;
  logic       o_down;
  logic       o_left;
  logic       o_right;
  logic       o_manual;
  logic       o_pending;

  modport master (
    output i_btn, i_auto_dir, i_autopilot, i_tick,
    input  o_up, o_down, o_left, o_right, o_manual, o_pending
  );

  modport slave (
    input  i_btn, i_auto_dir, i_autopilot, i_tick,
    output o_up, o_down, o_left, o_right, o_manual, o_pending
  );
endinterface

// File: rtl/direction_arbiter.sv
// Debounces four direction buttons and arbitrates between manual presses and an autopilot,
// committing one direction per rising edge of the game tick.
module direction_arbiter #(
  parameter int DB_CYCLES  = 250000,
  parameter int HOLD_TICKS = 8
) (
  input logic                CLKOUT0,
  input logic                rst_n,
  direction_arbiter_if.slave bus
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  logic [3:0] db_vec;
  logic [3:0] db_prev_reg;
  logic [3:0] dir_reg;
  logic [3:0] pending_dir_reg;
  logic       pending_reg;
  logic       tick_prev_reg;
  logic [HW-1:0] hold_reg;
  state_t     state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic [1:0]    sync_reg;
      logic [CW-1:0] cnt_reg;
      logic          db_bit_reg;

      always_ff @(posedge CLKOUT0) begin
        if (!rst_n) begin
          sync_reg   <= 2'b00;
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[0], bus.i_btn[gi]};
          // The counter only runs while the synced level disagrees with the debounced one.
          if (sync_reg[1] == db_bit_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            db_bit_reg <= sync_reg[1];
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign db_vec[gi] = db_bit_reg;
    end
  endgenerate

  logic [3:0] press;
  logic [3:0] sel_dir;
  logic [3:0] rev_dir;
  logic       accepted;
  logic       tick_edge;
  logic       auto_valid;

  assign press = db_vec & ~db_prev_reg;

  always_comb begin
    sel_dir = 4'b0000;
    if (press[0])      sel_dir = 4'b0001;
    else if (press[1]) sel_dir = 4'b0010;
    else if (press[2]) sel_dir = 4'b0100;
    else if (press[3]) sel_dir = 4'b1000;
  end

  // Swap up<->down and left<->right to get the opposite of the committed heading.
  assign rev_dir    = {dir_reg[2], dir_reg[3], dir_reg[0], dir_reg[1]};
  assign accepted   = (sel_dir != 4'b0000) && (sel_dir != rev_dir);
  assign tick_edge  = bus.i_tick && !tick_prev_reg;
  assign auto_valid = $onehot(bus.i_auto_dir);

  always_ff @(posedge CLKOUT0) begin
    if (!rst_n) begin
      db_prev_reg     <= 4'b0000;
      tick_prev_reg   <= 1'b0;
      dir_reg         <= 4'b0000;
      pending_dir_reg <= 4'b0000;
      pending_reg     <= 1'b0;
      hold_reg        <= '0;
      state_reg       <= MANUAL;
    end else begin
      db_prev_reg   <= db_vec;
      tick_prev_reg <= bus.i_tick;

      if (accepted) pending_dir_reg <= sel_dir;

      // A press landing on the tick edge itself takes effect immediately.
      if (tick_edge) begin
        pending_reg <= 1'b0;
        if (accepted) begin
          dir_reg <= sel_dir;
        end else if (state_reg == MANUAL) begin
          if (pending_reg) dir_reg <= pending_dir_reg;
        end else if (auto_valid) begin
          dir_reg <= bus.i_auto_dir;
        end
      end else if (accepted) begin
        pending_reg <= 1'b1;
      end

      if (!bus.i_autopilot || accepted) begin
        state_reg <= MANUAL;
      end else if (tick_edge && state_reg == MANUAL && hold_reg == '0) begin
        state_reg <= AUTO;
      end

      if (accepted) begin
        hold_reg <= HOLD_LOAD;
      end else if (tick_edge && state_reg == MANUAL && bus.i_autopilot && hold_reg != '0) begin
        hold_reg <= hold_reg - 1'b1;
      end
    end
  end

  assign bus.o_up      = dir_reg[0];
  assign bus.o_down    = dir_reg[1];
  assign bus.o_left    = dir_reg[2];
  assign bus.o_right   = dir_reg[3];
  assign bus.o_pending = pending_reg;
  assign bus.o_manual  = (state_reg == MANUAL);
endmodule

// File: tb/tb_direction_arbiter.sv
// Directed scenarios plus randomized traffic for direction_arbiter, compared every cycle
// against a behavioural model built from run-lengths and direction codes.
module tb_direction_arbiter;
  localparam int DB   = 4;
  localparam int HOLD = 2;

  logic CLKOUT0 = 1'b0;
  logic rst_n;

  direction_arbiter_if bif ();

  direction_arbiter #(.DB_CYCLES(DB), .HOLD_TICKS(HOLD)) dut (
    .CLKOUT0 (CLKOUT0),
    .rst_n   (rst_n),
    .bus     (bif.slave)
  );

  always #5 CLKOUT0 = ~CLKOUT0;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  // Model state: directions are codes 0=none, 1=up, 2=down, 3=left, 4=right.
  logic [3:0] delay0, delay1;
  logic [3:0] m_db, m_db_prev;
  int         run [4];
  logic       m_tick_prev, m_pending, m_manual;
  int         m_dir, m_pdir, m_hold;

  function automatic int rev_code(int c);
    if (c == 0) return 0;
    return (c % 2 == 1) ? c + 1 : c - 1;
  endfunction

  function automatic int code_of(logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return b + 1;
    return 0;
  endfunction

  function automatic logic [3:0] vec_of(int c);
    logic [3:0] v;
    v = 4'b0000;
    if (c != 0) v[c-1] = 1'b1;
    return v;
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] press;
    int  sel, acc, old_manual, old_hold;
    bit  te;
    if (!rst_n) begin
      delay0 = '0; delay1 = '0; m_db = '0; m_db_prev = '0;
      for (int b = 0; b < 4; b++) run[b] = 0;
      m_tick_prev = 0; m_pending = 0; m_manual = 1;
      m_dir = 0; m_pdir = 0; m_hold = 0;
      return;
    end
    press = m_db & ~m_db_prev;
    sel   = code_of(press);
    acc   = (sel != 0 && sel != rev_code(m_dir)) ? 1 : 0;
    te    = bif.i_tick && !m_tick_prev;
    old_manual = m_manual;
    old_hold   = m_hold;

    if (te) begin
      if (acc != 0) m_dir = sel;
      else if (old_manual != 0) begin
        if (m_pending) m_dir = m_pdir;
      end else if ($countones(bif.i_auto_dir) == 1) m_dir = code_of(bif.i_auto_dir);
      m_pending = 0;
    end else if (acc != 0) m_pending = 1;
    if (acc != 0) m_pdir = sel;

    if (!bif.i_autopilot || acc != 0) m_manual = 1;
    else if (te && old_manual != 0 && old_hold == 0) m_manual = 0;
    if (acc != 0) m_hold = HOLD;
    else if (te && old_manual != 0 && bif.i_autopilot && old_hold > 0) m_hold = old_hold - 1;

    // A debounced bit flips once the synced level has disagreed for DB cycles in a row.
    m_db_prev = m_db;
    for (int b = 0; b < 4; b++) begin
      if (delay1[b] == m_db[b]) run[b] = 0;
      else begin
        run[b]++;
        if (run[b] == DB) begin
          m_db[b] = delay1[b];
          run[b]  = 0;
        end
      end
    end
    delay1 = delay0;
    delay0 = bif.i_btn;
    m_tick_prev = bif.i_tick;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLKOUT0);
    @(negedge CLKOUT0);
    check("dir", {bif.o_right, bif.o_left, bif.o_down, bif.o_up}, vec_of(m_dir));
    check("manual", {3'b000, bif.o_manual}, {3'b000, m_manual});
    check("pending", {3'b000, bif.o_pending}, {3'b000, m_pending});
  endtask

  task automatic press_btn(logic [3:0] b);
    bif.i_btn = b;
    repeat (8) cycle();
    bif.i_btn = 4'b0000;
    repeat (8) cycle();
  endtask

  task automatic do_tick();
    bif.i_tick = 1'b1;
    cycle();
    bif.i_tick = 1'b0;
    cycle();
    ticks++;
    $display("tick %0d dir=%b manual=%b pending=%b", ticks,
             {bif.o_right, bif.o_left, bif.o_down, bif.o_up}, bif.o_manual, bif.o_pending);
  endtask

  function automatic logic [3:0] dir_now();
    return {bif.o_right, bif.o_left, bif.o_down, bif.o_up};
  endfunction

  initial begin
    int dur;
    rst_n = 1'b0;
    bif.i_btn = 4'b0000;
    bif.i_auto_dir = 4'b0000;
    bif.i_autopilot = 1'b0;
    bif.i_tick = 1'b0;
    repeat (2) cycle();
    check("rst_dir", dir_now(), 4'b0000);
    check("rst_manual", {3'b000, bif.o_manual}, 4'b0001);
    check("rst_pending", {3'b000, bif.o_pending}, 4'b0000);
    rst_n = 1'b1;
    cycle();

    // Short glitch is filtered; a held press is latched and committed on the tick.
    bif.i_btn = 4'b0001;
    repeat (2) cycle();
    bif.i_btn = 4'b0000;
    repeat (10) cycle();
    check("glitch_pending", {3'b000, bif.o_pending}, 4'b0000);
    press_btn(4'b0001);
    check("held_pending", {3'b000, bif.o_pending}, 4'b0001);
    check("held_dir_before_tick", dir_now(), 4'b0000);
    do_tick();
    check("up_after_tick", dir_now(), 4'b0001);
    check("pending_cleared", {3'b000, bif.o_pending}, 4'b0000);

    // Reverse press is ignored; the last of two accepted presses wins.
    press_btn(4'b0010);
    check("reverse_ignored", {3'b000, bif.o_pending}, 4'b0000);
    do_tick();
    check("still_up", dir_now(), 4'b0001);
    press_btn(4'b0100);
    press_btn(4'b1000);
    check("overwrite_pending", {3'b000, bif.o_pending}, 4'b0001);
    do_tick();
    check("right_wins", dir_now(), 4'b1000);

    // Simultaneous up+left: up has priority.
    press_btn(4'b0101);
    do_tick();
    check("priority_up", dir_now(), 4'b0001);

    // Reset while a press is pending.
    press_btn(4'b1000);
    do_tick();
    press_btn(4'b0010);
    check("pre_rst_pending", {3'b000, bif.o_pending}, 4'b0001);
    check("pre_rst_dir", dir_now(), 4'b1000);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("midrst_dir", dir_now(), 4'b0000);
    check("midrst_manual", {3'b000, bif.o_manual}, 4'b0001);
    check("midrst_pending", {3'b000, bif.o_pending}, 4'b0000);

    // Autopilot handover and hold-off after a manual press.
    bif.i_autopilot = 1'b1;
    bif.i_auto_dir = 4'b0100;
    do_tick();
    check("auto_entered", {3'b000, bif.o_manual}, 4'b0000);
    check("auto_first_dir", dir_now(), 4'b0000);
    do_tick();
    check("auto_left", dir_now(), 4'b0100);
    press_btn(4'b0010);
    check("press_takes_manual", {3'b000, bif.o_manual}, 4'b0001);
    do_tick();
    check("manual_down", dir_now(), 4'b0010);
    do_tick();
    check("hold_manual", {3'b000, bif.o_manual}, 4'b0001);
    do_tick();
    check("back_to_auto", {3'b000, bif.o_manual}, 4'b0000);
    check("back_to_auto_dir", dir_now(), 4'b0010);
    do_tick();
    check("auto_left_again", dir_now(), 4'b0100);
    bif.i_auto_dir = 4'b0011;
    do_tick();
    check("invalid_auto_held", dir_now(), 4'b0100);

    // Randomized traffic against the model.
    dur = 0;
    for (int n = 0; n < 3000; n++) begin
      if (dur == 0) begin
        bif.i_btn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        dur = $urandom_range(1, 14);
      end
      dur--;
      bif.i_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 60) == 0) bif.i_autopilot = ~bif.i_autopilot;
      if ($urandom_range(0, 10) == 0)
        bif.i_auto_dir = ($urandom_range(0, 1) == 1) ? vec_of($urandom_range(1, 4))
                                                     : 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 400) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/direction_arbiter.md
DIRECTION_ARBITER -- requirements
Module: direction_arbiter

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000, number of consecutive stable cycles (~10 ms at 25.174 MHz) before a debounced button changes.
REQ-002 SHALL have parameter HOLD_TICKS, default 8, number of game ticks manual input keeps control after the last press while autopilot is enabled.
REQ-003 SHALL have port CLKOUT0  input  1  VGA pixel clock; sole clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_btn  input  4  raw asynchronous buttons {right,left,down,up} (bit 0 = up).
REQ-006 SHALL have port i_auto_dir  input  4  autopilot direction request, same bit order, expected one-hot.
REQ-007 SHALL have port i_autopilot  input  1  autopilot enable level.
REQ-008 SHALL have port i_tick  input  1  game tick level; each rising edge is one move.
REQ-009 SHALL have ports o_up, o_down, o_left, o_right  output  1 each  committed direction, at most one high.
REQ-010 SHALL have port o_manual  output  1  1 = manual source in control, 0 = autopilot.
REQ-011 SHALL have port o_pending  output  1  a manual direction is latched awaiting the next tick.

Function
REQ-012 SHALL pass each i_btn bit through a 2-flop synchronizer before any other logic.
REQ-013 SHALL debounce each bit independently: per-bit counter cleared whenever synced value equals debounced value; debounced value takes synced value when counter reaches DB_CYCLES-1 differing cycles; counter width = clog2(DB_CYCLES), no wrap.
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of a debounced bit; releases generate nothing.
REQ-015 SHALL resolve simultaneous press events with priority up > down > left > right.
REQ-016 SHALL ignore a press that is the exact reverse of the committed direction (up/down, left/right); pending and hold counter unchanged.
REQ-017 SHALL latch an accepted press into pending_dir and set o_pending; a later accepted press before the tick overwrites it.
REQ-018 SHALL detect the tick edge as i_tick=1 with the previous-cycle i_tick=0 (registered).
REQ-019 SHALL, on a tick edge, commit the direction: MANUAL state -> pending_dir if o_pending, else previous committed value; AUTO state -> i_auto_dir if exactly one bit is set, else previous committed value.
REQ-020 SHALL change outputs only in the cycle after a tick edge, then hold them constant until the next tick edge.
REQ-021 SHALL clear o_pending on every tick edge.
REQ-022 SHALL treat a press event coinciding with the tick-edge cycle as pending for that tick (commits immediately; o_pending ends low).
REQ-023 SHALL implement source FSM {MANUAL, AUTO}: i_autopilot=0 forces MANUAL; AUTO -> MANUAL on any accepted press, hold counter loaded with HOLD_TICKS; in MANUAL with i_autopilot=1, each tick edge without an accepted press decrements hold; tick edge with hold=0 -> AUTO.
REQ-024 SHALL reload hold to HOLD_TICKS on every accepted press while MANUAL; hold saturates at 0.
REQ-025 SHALL drive o_manual = (state == MANUAL).
REQ-026 SHALL evaluate a transition to AUTO in the same tick edge that commits, using the AUTO rule only from the next tick edge.

Reset
REQ-027 SHALL, when rst_n=0 at a CLKOUT0 edge: all direction outputs 0, o_pending 0, state MANUAL (o_manual 1), hold 0, debounced values 0, debounce counters 0, synchronizers 0, previous-tick register 0.
REQ-028 SHALL apply reset mid-operation within one cycle, discarding pending and in-progress debounce.

Verification (DB_CYCLES=4, HOLD_TICKS=2)
REQ-029 SHALL check: i_btn[0] pulse 2 cycles -> no press, o_pending stays 0; held 8 cycles -> o_pending 1, next tick edge -> o_up 1 one cycle later.
REQ-030 SHALL check: committed o_up=1, press down -> o_pending 0, after tick o_up still 1; press left then right before tick -> o_right 1 after tick.
REQ-031 SHALL check: up and left debounced same cycle -> o_up after tick.
REQ-032 SHALL check: i_autopilot=1, i_auto_dir=4'b0100 -> o_manual 0 after first tick, o_left 1; press down -> o_manual 1, o_down 1 next tick; 2 ticks without press -> o_manual 0 at third tick, o_left 1 at fourth tick; i_auto_dir=4'b0011 -> direction held.
REQ-033 SHALL check: o_pending=1 and o_right=1, assert rst_n=0 one cycle -> all outputs 0, o_manual 1, o_pending 0 next cycle.
